// File: rtl/ft_bus_arbiter_if.sv
// ============================================================================
// ft_bus_arbiter_if
// Bundles the FT60x pad-side strobes/data and the gateway TX/RX FIFO
// handshakes seen by ft_bus_arbiter. "master" is the arbiter's view,
// "slave" is the view of the pads plus FIFOs around it.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ft_bus_arbiter_if;
  // FT60x pad side
  logic        txe_n_in;
  logic        rxf_n_in;
  logic        wr_n_out;
  logic        rd_n_out;
  logic        oe_n_out;
  logic        data_oe_out;
  logic [31:0] data_out;
  logic [3:0]  be_out;
  logic [31:0] data_in;
  logic [3:0]  be_in;
  // TX FIFO (first-word-fall-through) side
  logic        tx_empty_in;
  logic [31:0] tx_data_in;
  logic [3:0]  tx_be_in;
  logic        tx_rd_en_out;
  // RX FIFO side
  logic        rx_afull_in;
  logic        rx_wr_en_out;
  logic [31:0] rx_data_out;
  logic [3:0]  rx_be_out;

  modport master (
    input  txe_n_in, rxf_n_in, data_in, be_in,
    input  tx_empty_in, tx_data_in, tx_be_in, rx_afull_in,
    output wr_n_out, rd_n_out, oe_n_out, data_oe_out, data_out, be_out,
    output tx_rd_en_out, rx_wr_en_out, rx_data_out, rx_be_out
  );

  modport slave (
    output txe_n_in, rxf_n_in, data_in, be_in,
    output tx_empty_in, tx_data_in, tx_be_in, rx_afull_in,
    input  wr_n_out, rd_n_out, oe_n_out, data_oe_out, data_out, be_out,
    input  tx_rd_en_out, rx_wr_en_out, rx_data_out, rx_be_out
  );
endinterface

`default_nettype wire

// File: rtl/ft_bus_arbiter.sv
// ============================================================================
// ft_bus_arbiter
// Direction arbiter / sequencer for the 32-bit FT60x synchronous-FIFO bus.
// Grants the shared bus to TX (host-bound) or RX (FPGA-bound) bursts of at
// most MAX_BURST words, alternating on ties, with one GAP cycle after every
// burst for bus turnaround. Optional macro FT_ARB_STATS_EN adds free-running
// 32-bit TX/RX transfer counters (tx_words_out / rx_words_out).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ft_bus_arbiter #(
  parameter int MAX_BURST = 256
) (
  input  logic             clk_in,
  input  logic             rst_in,
  ft_bus_arbiter_if.master bus
`ifdef FT_ARB_STATS_EN
  ,
  output logic [31:0]      tx_words_out,
  output logic [31:0]      rx_words_out
`endif
);

  localparam int            CW       = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TX_BURST = 3'd1,
    S_RX_OE    = 3'd2,
    S_RX_BURST = 3'd3,
    S_GAP      = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          last_tx_q, last_tx_d;   // 1: last grant went to TX
  logic          rx_wr_en_q;
  logic [31:0]   rx_data_q;
  logic [3:0]    rx_be_q;

  logic tx_req, rx_req;
  logic tx_xfer, rx_xfer;
  logic wr_n, rd_n, oe_n, data_oe;

  // Arbitration, burst sequencing and strobe decode from the state register
  always_comb begin
    tx_req    = !bus.txe_n_in && !bus.tx_empty_in;
    rx_req    = !bus.rxf_n_in && !bus.rx_afull_in;
    state_d   = state_q;
    count_d   = count_q;
    last_tx_d = last_tx_q;
    tx_xfer   = 1'b0;
    rx_xfer   = 1'b0;
    wr_n      = 1'b1;
    rd_n      = 1'b1;
    oe_n      = 1'b1;
    data_oe   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // On a tie the direction not granted last time wins
        if (tx_req && (!rx_req || !last_tx_q)) begin
          state_d   = S_TX_BURST;
          last_tx_d = 1'b1;
          count_d   = '0;
        end else if (rx_req) begin
          state_d   = S_RX_OE;
          last_tx_d = 1'b0;
          count_d   = '0;
        end
      end
      S_TX_BURST: begin
        data_oe = 1'b1;
        wr_n    = bus.tx_empty_in;
        tx_xfer = !bus.tx_empty_in && !bus.txe_n_in;
        if (tx_xfer) count_d = count_q + CW'(1);
        if (bus.txe_n_in || bus.tx_empty_in || (tx_xfer && count_q == LAST_CNT))
          state_d = S_GAP;
      end
      S_RX_OE: begin
        // FT60x needs OE_N low one cycle before RD_N
        oe_n    = 1'b0;
        state_d = S_RX_BURST;
      end
      S_RX_BURST: begin
        oe_n    = 1'b0;
        rd_n    = 1'b0;
        rx_xfer = !bus.rxf_n_in;
        if (rx_xfer) count_d = count_q + CW'(1);
        if (bus.rxf_n_in || bus.rx_afull_in || (rx_xfer && count_q == LAST_CNT))
          state_d = S_GAP;
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, burst counter and tie-break history
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      last_tx_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      last_tx_q <= last_tx_d;
    end
  end

  // Capture each RX bus word and push it to the RX FIFO one cycle later
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wr_en_q <= 1'b0;
      rx_data_q  <= '0;
      rx_be_q    <= '0;
    end else begin
      rx_wr_en_q <= rx_xfer;
      if (rx_xfer) begin
        rx_data_q <= bus.data_in;
        rx_be_q   <= bus.be_in;
      end
    end
  end

`ifdef FT_ARB_STATS_EN
  logic [31:0] tx_words_q, rx_words_q;

  // Free-running transfer counters, wrapping modulo 2^32
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      tx_words_q <= '0;
      rx_words_q <= '0;
    end else begin
      if (tx_xfer) tx_words_q <= tx_words_q + 32'd1;
      if (rx_xfer) rx_words_q <= rx_words_q + 32'd1;
    end
  end

  assign tx_words_out = tx_words_q;
  assign rx_words_out = rx_words_q;
`endif

  assign bus.wr_n_out     = wr_n;
  assign bus.rd_n_out     = rd_n;
  assign bus.oe_n_out     = oe_n;
  assign bus.data_oe_out  = data_oe;
  assign bus.data_out     = data_oe ? bus.tx_data_in : 32'h0;
  assign bus.be_out       = data_oe ? bus.tx_be_in : 4'h0;
  assign bus.tx_rd_en_out = tx_xfer;
  assign bus.rx_wr_en_out = rx_wr_en_q;
  assign bus.rx_data_out  = rx_data_q;
  assign bus.rx_be_out    = rx_be_q;

endmodule

`default_nettype wire

// File: doc/ft_bus_arbiter.md
# ft_bus_arbiter

Sequencer and direction arbiter for the 32-bit FT60x synchronous-FIFO bus. It runs entirely in the FTDI clock domain, between the gateway's TX/RX FIFOs and the top-level `DATA`/`BE` pads. It grants the shared bus to host-bound writes (TX) or FPGA-bound reads (RX), and drives `WR_N`/`RD_N`/`OE_N` and the pad tri-state enable. It enforces burst limits and a turnaround gap between ownership changes.

## Interface
Parameters:
- `MAX_BURST`, 256: maximum words per grant, legal range 1..65535. The counter width is `$clog2(MAX_BURST+1)`.

Ports:
- `clk_in`  in  1  FTDI bus clock (100 MHz).
- `rst_in`  in  1  Reset, asynchronous, active-low.
- `txe_n_in`  in  1  FT60x TX FIFO has space (low).
- `rxf_n_in`  in  1  FT60x RX FIFO has data (low).
- `wr_n_out`  out  1  FT60x write strobe.
- `rd_n_out`  out  1  FT60x read strobe.
- `oe_n_out`  out  1  FT60x data output enable.
- `data_oe_out`  out  1  FPGA drives `DATA`/`BE` when high; the top level builds the tri-state.
- `data_out`  out  32  Write data to the pads.
- `be_out`  out  4  Write byte enables to the pads.
- `data_in`  in  32  Read data from the pads.
- `be_in`  in  4  Read byte enables from the pads.
- `tx_empty_in`  in  1  TX FIFO empty. The TX FIFO is first-word-fall-through.
- `tx_data_in`  in  32  TX FIFO head word.
- `tx_be_in`  in  4  TX FIFO head byte enables.
- `tx_rd_en_out`  out  1  Pop the TX FIFO head.
- `rx_afull_in`  in  1  RX FIFO almost full; guarantees at least 2 free entries.
- `rx_wr_en_out`  out  1  Push to the RX FIFO.
- `rx_data_out`  out  32  RX push data.
- `rx_be_out`  out  4  RX push byte enables.

## Operation
- The state register holds one of IDLE, TX_BURST, RX_OE, RX_BURST, GAP. Reset state is IDLE.
- Requests:
  - `tx_req = !txe_n_in && !tx_empty_in`
  - `rx_req = !rxf_n_in && !rx_afull_in`
- IDLE transitions:
  - Only `tx_req` → TX_BURST.
  - Only `rx_req` → RX_OE.
  - Both → the direction opposite to `last_grant`. `last_grant` resets to RX, so TX wins the first tie.
  - `last_grant` updates on every grant.
  - The burst counter clears on every grant.
- TX_BURST:
  - `data_oe_out = 1`.
  - `data_out`/`be_out` = `tx_data_in`/`tx_be_in`.
  - `wr_n_out = tx_empty_in`.
  - Transfer occurs when `!wr_n_out && !txe_n_in`. On a transfer, `tx_rd_en_out = 1` and the counter increments.
  - Exit to GAP on: `txe_n_in` high, `tx_empty_in` high, or a transfer with `count == MAX_BURST-1`.
- RX_OE: `oe_n_out = 0`, `rd_n_out = 1`, one cycle, then RX_BURST.
- RX_BURST:
  - `oe_n_out = 0`.
  - `rd_n_out = 0`.
  - Transfer occurs when `!rxf_n_in`. Its data/BE are registered to `rx_data_out`/`rx_be_out`, with `rx_wr_en_out = 1` on the next cycle. The counter increments.
  - Exit to GAP on: `rxf_n_in` high, `rx_afull_in` high, or a transfer with `count == MAX_BURST-1`.
- GAP: all strobes high, `data_oe_out = 0`; one cycle, then IDLE. This guarantees bus turnaround and FT60x strobe recovery.
- `data_oe_out` is never high outside TX_BURST.
- `oe_n_out` is never low while `data_oe_out` is high.
- Reset values:
  - `wr_n_out`, `rd_n_out`, `oe_n_out` = 1.
  - `data_oe_out`, `tx_rd_en_out`, `rx_wr_en_out` = 0.
  - `data_out`, `be_out`, `rx_data_out`, `rx_be_out` = 0.
  - Counter = 0.
- Reset mid-burst forces the reset values immediately, asynchronously. Any in-flight RX word is dropped.

## Timing
- The state, counter, `last_grant` and RX capture registers are clocked on the rising edge of `clk_in`.
- `wr_n_out`, `rd_n_out`, `oe_n_out` and `data_oe_out` are decoded from the state register. `wr_n_out` additionally gates with `tx_empty_in`.
- `tx_rd_en_out` is combinational from state, `tx_empty_in` and `txe_n_in`.
- Grant latency: a request seen in IDLE puts the bus active on the next cycle. For RX, `RD_N` falls 2 cycles after grant.
- RX push latency: 1 cycle after the bus transfer.
- Throughput: 1 word per cycle during a burst.
- Overhead: 1 GAP cycle per TX burst; 1 RX_OE + 1 GAP cycle per RX burst.

## Configuration
- `FT_ARB_STATS_EN` defined:
  - Adds outputs `tx_words_out[31:0]` and `rx_words_out[31:0]`.
  - These are free-running counts of TX and RX bus transfers. They wrap modulo 2^32 and reset to 0.
- `FT_ARB_STATS_EN` undefined: the ports and counters are absent. The rest of the behaviour is identical.

## Test plan
- Reset, then TX FIFO holding 3 words with `txe_n_in = 0`:
  - Required: `wr_n_out` low for exactly 3 cycles, with `data_out` = W0, W1, W2.
  - Then 1 GAP cycle, then IDLE with `data_oe_out = 0`.
- RX only, `rxf_n_in` low for 5 words:
  - Required: `oe_n_out` falls 1 cycle before `rd_n_out`.
  - `rx_wr_en_out` pulses 5 times, each 1 cycle after its bus word.
  - Captured data matches the pad data.
- `MAX_BURST = 4`, TX holding 10 words:
  - Required: bursts of 4, 4, 2, each separated by exactly 1 GAP cycle.
- `tx_req` and `rx_req` both held continuously:
  - Required: grants alternate TX, RX, TX after reset.
  - No cycle ever has `data_oe_out = 1` together with `oe_n_out = 0`.
- TX burst with `txe_n_in` raised mid-burst after 2 words:
  - Required: exactly 2 pops, then GAP, then TX re-granted when `txe_n_in` drops.
- `rst_in` asserted during RX_BURST:
  - Required: all strobes high and `rx_wr_en_out = 0` immediately.
  - With `FT_ARB_STATS_EN`, the counters read 0.
